// File: rtl/control_unit.sv
// control_unit: Moore-style sequencer for an 8-bit accumulator CPU datapath.
// Fetches a one-byte opcode, decodes it, and walks through the execute states
// for that opcode. Every strobe is registered and is a pure function of the
// current state. Optional HALT opcode (8'h10) is enabled by macro CU_HALT_EN.
//
// Ports:
//   clock, reset_n       : rising-edge clock, asynchronous active-low reset
//   ir[7:0], z           : instruction register and zero flag from the datapath
//   we .. Zload          : active-high datapath control strobes
//   ALUS[6:0]            : ALU operation select
//   halted               : processor stopped (always 0 without CU_HALT_EN)
module control_unit (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] ir,
    input  logic       z,
    output logic       we,
    output logic       MEMbus,
    output logic       BUSmem,
    output logic       ARload,
    output logic       ARinc,
    output logic       PCload,
    output logic       PCinc,
    output logic       PCbus,
    output logic       DRload,
    output logic       DRHbus,
    output logic       DRLbus,
    output logic       TRload,
    output logic       TRbus,
    output logic       IRload,
    output logic       Rload,
    output logic       Rbus,
    output logic       ACload,
    output logic       ACbus,
    output logic       Zload,
    output logic [6:0] ALUS,
    output logic       halted
);

    localparam int unsigned ALUS_W = 7;

    localparam logic [ALUS_W-1:0] ALU_PASS = 7'h00;
    localparam logic [ALUS_W-1:0] ALU_ADD  = 7'h01;
    localparam logic [ALUS_W-1:0] ALU_SUB  = 7'h02;
    localparam logic [ALUS_W-1:0] ALU_INC  = 7'h03;
    localparam logic [ALUS_W-1:0] ALU_CLR  = 7'h04;
    localparam logic [ALUS_W-1:0] ALU_AND  = 7'h05;
    localparam logic [ALUS_W-1:0] ALU_OR   = 7'h06;
    localparam logic [ALUS_W-1:0] ALU_XOR  = 7'h07;
    localparam logic [ALUS_W-1:0] ALU_NOT  = 7'h08;

    typedef enum logic [4:0] {
        IDLE, FETCH1, FETCH2, FETCH3, DECODE,
        A1, A2, A3, L4, L5, S4, S5,
        MVAC1, MOVR1,
        J1, J2, J3, N1, N2,
        ADD1, SUB1, INAC1, CLAC1, AND1, OR1, XOR1, NOT1,
        HALT
    } state_t;

    typedef struct packed {
        logic              we;
        logic              mem_bus;
        logic              bus_mem;
        logic              ar_load;
        logic              ar_inc;
        logic              pc_load;
        logic              pc_inc;
        logic              pc_bus;
        logic              dr_load;
        logic              drh_bus;
        logic              drl_bus;
        logic              tr_load;
        logic              tr_bus;
        logic              ir_load;
        logic              r_load;
        logic              r_bus;
        logic              ac_load;
        logic              ac_bus;
        logic              z_load;
        logic [ALUS_W-1:0] alus;
    } ctrl_t;

    state_t state_q, state_d;
    logic   store_q, store_d;   // remembers STAC vs LDAC across the shared A1..A3
    ctrl_t  ctrl_q, ctrl_d;

    // State, opcode-class flag and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next state, then the strobes of that next state so the registered
    // outputs line up exactly with the state register.
    always_comb begin
        state_d = state_q;
        store_d = store_q;
        ctrl_d  = '0;

        case (state_q)
            IDLE:   state_d = FETCH1;
            FETCH1: state_d = FETCH2;
            FETCH2: state_d = FETCH3;
            FETCH3: state_d = DECODE;
            DECODE: begin
                case (ir)
                    8'h01: begin state_d = A1; store_d = 1'b0; end
                    8'h02: begin state_d = A1; store_d = 1'b1; end
                    8'h03: state_d = MVAC1;
                    8'h04: state_d = MOVR1;
                    8'h05: state_d = J1;
                    8'h06: state_d = z ? J1 : N1;
                    8'h07: state_d = z ? N1 : J1;
                    8'h08: state_d = ADD1;
                    8'h09: state_d = SUB1;
                    8'h0A: state_d = INAC1;
                    8'h0B: state_d = CLAC1;
                    8'h0C: state_d = AND1;
                    8'h0D: state_d = OR1;
                    8'h0E: state_d = XOR1;
                    8'h0F: state_d = NOT1;
`ifdef CU_HALT_EN
                    8'h10: state_d = HALT;
`endif
                    default: state_d = FETCH1;
                endcase
            end
            A1:     state_d = A2;
            A2:     state_d = A3;
            A3:     state_d = store_q ? S4 : L4;
            L4:     state_d = L5;
            S4:     state_d = S5;
            J1:     state_d = J2;
            J2:     state_d = J3;
            N1:     state_d = N2;
            HALT:   state_d = HALT;
            default: state_d = FETCH1;
        endcase

        case (state_d)
            FETCH1: begin ctrl_d.pc_bus = 1'b1; ctrl_d.ar_load = 1'b1; end
            FETCH2: begin
                ctrl_d.mem_bus = 1'b1; ctrl_d.dr_load = 1'b1; ctrl_d.pc_inc = 1'b1;
            end
            FETCH3: ctrl_d.ir_load = 1'b1;
            A1: begin
                ctrl_d.mem_bus = 1'b1; ctrl_d.dr_load = 1'b1;
                ctrl_d.pc_inc  = 1'b1; ctrl_d.ar_inc  = 1'b1;
            end
            A2: begin
                ctrl_d.tr_load = 1'b1; ctrl_d.mem_bus = 1'b1;
                ctrl_d.dr_load = 1'b1; ctrl_d.pc_inc  = 1'b1;
            end
            A3: begin
                ctrl_d.drh_bus = 1'b1; ctrl_d.tr_bus = 1'b1; ctrl_d.ar_load = 1'b1;
            end
            L4: begin ctrl_d.mem_bus = 1'b1; ctrl_d.dr_load = 1'b1; end
            L5: begin
                ctrl_d.drl_bus = 1'b1; ctrl_d.ac_load = 1'b1; ctrl_d.alus = ALU_PASS;
            end
            S4: begin ctrl_d.ac_bus = 1'b1; ctrl_d.dr_load = 1'b1; end
            S5: begin
                ctrl_d.drl_bus = 1'b1; ctrl_d.bus_mem = 1'b1; ctrl_d.we = 1'b1;
            end
            MVAC1: begin ctrl_d.ac_bus = 1'b1; ctrl_d.r_load = 1'b1; end
            MOVR1: begin
                ctrl_d.r_bus = 1'b1; ctrl_d.ac_load = 1'b1; ctrl_d.alus = ALU_PASS;
            end
            J1: begin
                ctrl_d.mem_bus = 1'b1; ctrl_d.dr_load = 1'b1; ctrl_d.ar_inc = 1'b1;
            end
            J2: begin
                ctrl_d.tr_load = 1'b1; ctrl_d.mem_bus = 1'b1; ctrl_d.dr_load = 1'b1;
            end
            J3: begin
                ctrl_d.drh_bus = 1'b1; ctrl_d.tr_bus = 1'b1; ctrl_d.pc_load = 1'b1;
            end
            N1, N2: ctrl_d.pc_inc = 1'b1;
            ADD1, SUB1, AND1, OR1, XOR1: begin
                ctrl_d.r_bus  = 1'b1; ctrl_d.ac_load = 1'b1; ctrl_d.z_load = 1'b1;
                case (state_d)
                    ADD1:    ctrl_d.alus = ALU_ADD;
                    SUB1:    ctrl_d.alus = ALU_SUB;
                    AND1:    ctrl_d.alus = ALU_AND;
                    OR1:     ctrl_d.alus = ALU_OR;
                    default: ctrl_d.alus = ALU_XOR;
                endcase
            end
            INAC1: begin ctrl_d.ac_load = 1'b1; ctrl_d.z_load = 1'b1; ctrl_d.alus = ALU_INC; end
            CLAC1: begin ctrl_d.ac_load = 1'b1; ctrl_d.z_load = 1'b1; ctrl_d.alus = ALU_CLR; end
            NOT1:  begin ctrl_d.ac_load = 1'b1; ctrl_d.z_load = 1'b1; ctrl_d.alus = ALU_NOT; end
            default: ctrl_d = '0;
        endcase
    end

    assign we     = ctrl_q.we;
    assign MEMbus = ctrl_q.mem_bus;
    assign BUSmem = ctrl_q.bus_mem;
    assign ARload = ctrl_q.ar_load;
    assign ARinc  = ctrl_q.ar_inc;
    assign PCload = ctrl_q.pc_load;
    assign PCinc  = ctrl_q.pc_inc;
    assign PCbus  = ctrl_q.pc_bus;
    assign DRload = ctrl_q.dr_load;
    assign DRHbus = ctrl_q.drh_bus;
    assign DRLbus = ctrl_q.drl_bus;
    assign TRload = ctrl_q.tr_load;
    assign TRbus  = ctrl_q.tr_bus;
    assign IRload = ctrl_q.ir_load;
    assign Rload  = ctrl_q.r_load;
    assign Rbus   = ctrl_q.r_bus;
    assign ACload = ctrl_q.ac_load;
    assign ACbus  = ctrl_q.ac_bus;
    assign Zload  = ctrl_q.z_load;
    assign ALUS   = ctrl_q.alus;

`ifdef CU_HALT_EN
    logic halted_q;

    // Halt indicator registered alongside the strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) halted_q <= 1'b0;
        else          halted_q <= (state_d == HALT);
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic       clock, reset_n, z;
    logic [7:0] ir;
    logic we, MEMbus, BUSmem, ARload, ARinc, PCload, PCinc, PCbus, DRload;
    logic DRHbus, DRLbus, TRload, TRbus, IRload, Rload, Rbus, ACload, ACbus, Zload;
    logic [6:0] ALUS;
    logic       halted;

    control_unit dut (
        .clock(clock), .reset_n(reset_n), .ir(ir), .z(z),
        .we(we), .MEMbus(MEMbus), .BUSmem(BUSmem), .ARload(ARload), .ARinc(ARinc),
        .PCload(PCload), .PCinc(PCinc), .PCbus(PCbus), .DRload(DRload),
        .DRHbus(DRHbus), .DRLbus(DRLbus), .TRload(TRload), .TRbus(TRbus),
        .IRload(IRload), .Rload(Rload), .Rbus(Rbus), .ACload(ACload),
        .ACbus(ACbus), .Zload(Zload), .ALUS(ALUS), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observation vector bit positions.
    localparam logic [26:0] M_WE     = 27'(1) << 26;
    localparam logic [26:0] M_MEMBUS = 27'(1) << 25;
    localparam logic [26:0] M_BUSMEM = 27'(1) << 24;
    localparam logic [26:0] M_ARLOAD = 27'(1) << 23;
    localparam logic [26:0] M_ARINC  = 27'(1) << 22;
    localparam logic [26:0] M_PCLOAD = 27'(1) << 21;
    localparam logic [26:0] M_PCINC  = 27'(1) << 20;
    localparam logic [26:0] M_PCBUS  = 27'(1) << 19;
    localparam logic [26:0] M_DRLOAD = 27'(1) << 18;
    localparam logic [26:0] M_DRHBUS = 27'(1) << 17;
    localparam logic [26:0] M_DRLBUS = 27'(1) << 16;
    localparam logic [26:0] M_TRLOAD = 27'(1) << 15;
    localparam logic [26:0] M_TRBUS  = 27'(1) << 14;
    localparam logic [26:0] M_IRLOAD = 27'(1) << 13;
    localparam logic [26:0] M_RLOAD  = 27'(1) << 12;
    localparam logic [26:0] M_RBUS   = 27'(1) << 11;
    localparam logic [26:0] M_ACLOAD = 27'(1) << 10;
    localparam logic [26:0] M_ACBUS  = 27'(1) << 9;
    localparam logic [26:0] M_ZLOAD  = 27'(1) << 8;
    localparam logic [26:0] M_HALTED = 27'(1);

    localparam logic [26:0] E_F1 = M_PCBUS | M_ARLOAD;
    localparam logic [26:0] E_J3 = M_DRHBUS | M_TRBUS | M_PCLOAD;
    localparam logic [26:0] E_RALU = M_RBUS | M_ACLOAD | M_ZLOAD;
    localparam logic [26:0] E_AALU = M_ACLOAD | M_ZLOAD;

    function automatic logic [26:0] alu(input int unsigned c);
        return 27'(c) << 1;
    endfunction

    function automatic logic [26:0] obs();
        return {we, MEMbus, BUSmem, ARload, ARinc, PCload, PCinc, PCbus, DRload,
                DRHbus, DRLbus, TRload, TRbus, IRload, Rload, Rbus, ACload, ACbus,
                Zload, ALUS, halted};
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit bus_conflict();
        int unsigned lo;
        lo = 32'(MEMbus) + 32'(PCbus) + 32'(DRLbus) + 32'(TRbus) + 32'(Rbus) + 32'(ACbus);
        return (lo > 1) || (DRHbus && PCbus);
    endfunction

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic        zf;
        int          len;
        logic [26:0] last;
        logic        pcl;
    } vec_t;

    // Runs one instruction starting with the DUT sampled in FETCH1.
    task automatic run_instr(input vec_t v);
        int          n;
        logic [26:0] prev;
        bit          pcl_seen, conflict;
        ir = v.op;
        z  = v.zf;
        check({v.name, "_f1"}, obs(), E_F1);
        n = 1; prev = obs(); pcl_seen = 1'b0; conflict = bus_conflict();
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (obs() == E_F1) break;
            prev = obs();
            pcl_seen |= PCload;
            conflict |= bus_conflict();
            n++;
        end
        check({v.name, "_len"}, 27'(n), 27'(v.len));
        check({v.name, "_last"}, prev, v.last);
        check({v.name, "_pcload"}, 27'(pcl_seen), 27'(v.pcl));
        check({v.name, "_busconf"}, 27'(conflict), 27'(0));
    endtask

    vec_t vecs[$];
    logic [26:0] ldac_tr[9];

    initial begin
        vecs.push_back('{"nop",   8'h00, 1'b0, 4, 27'(0), 1'b0});
        vecs.push_back('{"ldac",  8'h01, 1'b0, 9, M_DRLBUS | M_ACLOAD | alu(0), 1'b0});
        vecs.push_back('{"stac",  8'h02, 1'b0, 9, M_DRLBUS | M_BUSMEM | M_WE, 1'b0});
        vecs.push_back('{"mvac",  8'h03, 1'b0, 5, M_ACBUS | M_RLOAD, 1'b0});
        vecs.push_back('{"movr",  8'h04, 1'b1, 5, M_RBUS | M_ACLOAD, 1'b0});
        vecs.push_back('{"jump",  8'h05, 1'b0, 7, E_J3, 1'b1});
        vecs.push_back('{"jmpz1", 8'h06, 1'b1, 7, E_J3, 1'b1});
        vecs.push_back('{"jmpz0", 8'h06, 1'b0, 6, M_PCINC, 1'b0});
        vecs.push_back('{"jpnz0", 8'h07, 1'b0, 7, E_J3, 1'b1});
        vecs.push_back('{"jpnz1", 8'h07, 1'b1, 6, M_PCINC, 1'b0});
        vecs.push_back('{"add",   8'h08, 1'b0, 5, E_RALU | alu(1), 1'b0});
        vecs.push_back('{"sub",   8'h09, 1'b0, 5, E_RALU | alu(2), 1'b0});
        vecs.push_back('{"inac",  8'h0A, 1'b0, 5, E_AALU | alu(3), 1'b0});
        vecs.push_back('{"clac",  8'h0B, 1'b0, 5, E_AALU | alu(4), 1'b0});
        vecs.push_back('{"and",   8'h0C, 1'b0, 5, E_RALU | alu(5), 1'b0});
        vecs.push_back('{"or",    8'h0D, 1'b0, 5, E_RALU | alu(6), 1'b0});
        vecs.push_back('{"xor",   8'h0E, 1'b0, 5, E_RALU | alu(7), 1'b0});
        vecs.push_back('{"not",   8'h0F, 1'b0, 5, E_AALU | alu(8), 1'b0});
        vecs.push_back('{"ir_ff", 8'hFF, 1'b0, 4, 27'(0), 1'b0});
        vecs.push_back('{"ir_3c", 8'h3C, 1'b1, 4, 27'(0), 1'b0});

        ldac_tr[0] = E_F1;
        ldac_tr[1] = M_MEMBUS | M_DRLOAD | M_PCINC;
        ldac_tr[2] = M_IRLOAD;
        ldac_tr[3] = 27'(0);
        ldac_tr[4] = M_MEMBUS | M_DRLOAD | M_PCINC | M_ARINC;
        ldac_tr[5] = M_TRLOAD | M_MEMBUS | M_DRLOAD | M_PCINC;
        ldac_tr[6] = M_DRHBUS | M_TRBUS | M_ARLOAD;
        ldac_tr[7] = M_MEMBUS | M_DRLOAD;
        ldac_tr[8] = M_DRLBUS | M_ACLOAD;

        reset_n = 1'b0; ir = 8'h00; z = 1'b0;
        @(negedge clock); @(negedge clock);
        check("reset_outputs", obs(), 27'(0));
        reset_n = 1'b1;
        check("idle_outputs", obs(), 27'(0));
        @(negedge clock);

        foreach (vecs[i]) run_instr(vecs[i]);

        // Full LDAC trace, state by state.
        ir = 8'h01;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("ldac_trace%0d", k), obs(), ldac_tr[k]);
            @(negedge clock);
        end
        check("ldac_back_f1", obs(), E_F1);

        // z is sampled only in DECODE: flip it after the branch is taken.
        ir = 8'h06; z = 1'b1;
        repeat (4) @(negedge clock);
        z = 1'b0;
        check("jmpz_j1", obs(), M_MEMBUS | M_DRLOAD | M_ARINC);
        @(negedge clock); @(negedge clock);
        check("jmpz_j3", obs(), E_J3);
        @(negedge clock);
        check("jmpz_back_f1", obs(), E_F1);

        // Reset during STAC S4 (8th state after FETCH1).
        ir = 8'h02;
        repeat (7) @(negedge clock);
        check("stac_s4", obs(), M_ACBUS | M_DRLOAD);
        #2 reset_n = 1'b0;
        #1 check("stac_async_reset", obs(), 27'(0));
        @(negedge clock);
        check("stac_in_reset", obs(), 27'(0));
        reset_n = 1'b1;
        check("stac_idle", obs(), 27'(0));
        @(negedge clock);
        check("stac_restart_f1", obs(), E_F1);

`ifdef CU_HALT_EN
        ir = 8'h10;
        repeat (4) @(negedge clock);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("halt_c%0d", k), obs(), M_HALTED);
            @(negedge clock);
        end
        reset_n = 1'b0;
        #1 check("halt_reset", obs(), 27'(0));
        reset_n = 1'b1;
`else
        run_instr('{"ir_10", 8'h10, 1'b0, 4, 27'(0), 1'b0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
